// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase controller:
// phase encoding, BCD digit types and lamp decode.
package traffic_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    typedef enum logic [2:0] {
        NS_GO   = 3'd0,
        NS_WARN = 3'd1,
        CLR_A   = 3'd2,
        EW_GO   = 3'd3,
        EW_WARN = 3'd4,
        CLR_B   = 3'd5
    } phase_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    typedef struct packed {
        lamp_t ns;
        lamp_t ew;
    } lamps_t;

    function automatic bcd2_t to_bcd2(input int value);
        bcd2_t r;
        r.tens = bcd_t'((value / 10) % 10);
        r.ones = bcd_t'(value % 10);
        return r;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            NS_GO:   n = NS_WARN;
            NS_WARN: n = CLR_A;
            CLR_A:   n = EW_GO;
            EW_GO:   n = EW_WARN;
            EW_WARN: n = CLR_B;
            default: n = NS_GO;
        endcase
        return n;
    endfunction

    // Any encoding outside the go/warn phases shows red both ways.
    function automatic lamps_t lamps_for(input phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            NS_GO: begin
                l.ns.green = 1'b1;
                l.ew.red   = 1'b1;
            end
            NS_WARN: begin
                l.ns.yellow = 1'b1;
                l.ew.red    = 1'b1;
            end
            EW_GO: begin
                l.ns.red   = 1'b1;
                l.ew.green = 1'b1;
            end
            EW_WARN: begin
                l.ns.red    = 1'b1;
                l.ew.yellow = 1'b1;
            end
            default: begin
                l.ns.red = 1'b1;
                l.ew.red = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the phase controller (master) and the
// lamp/display/button side (slave).
interface traffic_phase_ctrl_if;
    import traffic_pkg::*;

    logic ped_req;
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    bcd_t cnt_tens;
    bcd_t cnt_ones;
    logic tick;

    modport master (
        input  ped_req,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output cnt_tens, cnt_ones, tick
    );

    modport slave (
        output ped_req,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  cnt_tens, cnt_ones, tick
    );

endinterface

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with synchronous load (priority) and
// decrement enable; flags when the count reads 01.
module bcd2_down_counter
    import traffic_pkg::*;
#(
    parameter bcd2_t RST_VAL = '0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  bcd2_t load_val_i,
    input  logic  dec_i,
    output bcd_t  tens_o,
    output bcd_t  ones_o,
    output logic  is_one_o
);

    bcd2_t cnt_q;
    bcd2_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            if (cnt_q.ones == 4'd0) begin
                cnt_d.ones = 4'd9;
                cnt_d.tens = cnt_q.tens - 4'd1;
            end else begin
                cnt_d.ones = cnt_q.ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tens_o   = cnt_q.tens;
    assign ones_o   = cnt_q.ones;
    assign is_one_o = (cnt_q == 8'h01);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-direction intersection sequencer with one-second prescaler and BCD
// countdown. Define TRAFFIC_PED_REQ_EN to build the pedestrian green cut.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_SEC   = 25,
    parameter int YELLOW_SEC  = 3,
    parameter int ALLRED_SEC  = 1,
    parameter int PED_MIN_SEC = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.master bus
);

    localparam int unsigned      DIV_W       = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam bcd2_t            GREEN_BCD   = to_bcd2(GREEN_SEC);
    localparam bcd2_t            YELLOW_BCD  = to_bcd2(YELLOW_SEC);
    localparam bcd2_t            ALLRED_BCD  = to_bcd2(ALLRED_SEC);
    localparam bcd2_t            PED_MIN_BCD = to_bcd2(PED_MIN_SEC);

    function automatic bcd2_t phase_dur(input phase_t p);
        bcd2_t d;
        case (p)
            NS_GO, EW_GO:     d = GREEN_BCD;
            NS_WARN, EW_WARN: d = YELLOW_BCD;
            default:          d = ALLRED_BCD;
        endcase
        return d;
    endfunction

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             tick_q;
    logic             tick_d;
    phase_t           state_q;
    phase_t           state_d;
    lamps_t           lamps_q;
    lamps_t           lamps_d;

    logic             cnt_load;
    bcd2_t            cnt_load_val;
    logic             cnt_dec;
    logic             cnt_is_one;
    bcd_t             cnt_tens;
    bcd_t             cnt_ones;
    bcd2_t            cnt_cur;
    logic             ped_cut;

    assign cnt_cur = '{tens: cnt_tens, ones: cnt_ones};

    // tick is registered so it is high exactly while div_cnt_q == TICK_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        tick_d    = (div_cnt_d == DIV_LAST);
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = GREEN_BCD;
        cnt_dec      = 1'b0;
        if (tick_q) begin
            if (cnt_is_one) begin
                state_d      = next_phase(state_q);
                cnt_load     = 1'b1;
                cnt_load_val = phase_dur(state_d);
            end else if (ped_cut) begin
                cnt_load     = 1'b1;
                cnt_load_val = PED_MIN_BCD;
            end else begin
                cnt_dec = 1'b1;
            end
        end
        lamps_d = lamps_for(state_d);
    end

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_latch_q;
    logic ped_latch_d;
    logic clr_entry;

    assign clr_entry = tick_q && cnt_is_one && (state_q == NS_WARN || state_q == EW_WARN);

    // A request arriving on the clearing edge survives and cuts the next green.
    always_comb begin
        ped_latch_d = ped_latch_q;
        if (clr_entry) begin
            ped_latch_d = 1'b0;
        end
        if (bus.ped_req) begin
            ped_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_latch_q <= 1'b0;
        end else begin
            ped_latch_q <= ped_latch_d;
        end
    end

    assign ped_cut = ped_latch_q && (state_q == NS_GO || state_q == EW_GO)
                     && (cnt_cur > PED_MIN_BCD);
`else
    logic [8:0] ped_unused;

    assign ped_unused = {bus.ped_req, PED_MIN_BCD};
    assign ped_cut    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            state_q   <= NS_GO;
            lamps_q   <= lamps_for(NS_GO);
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            lamps_q   <= lamps_d;
        end
    end

    bcd2_down_counter #(
        .RST_VAL (GREEN_BCD)
    ) u_count (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .tens_o     (cnt_tens),
        .ones_o     (cnt_ones),
        .is_one_o   (cnt_is_one)
    );

    assign bus.ns_red    = lamps_q.ns.red;
    assign bus.ns_yellow = lamps_q.ns.yellow;
    assign bus.ns_green  = lamps_q.ns.green;
    assign bus.ew_red    = lamps_q.ew.red;
    assign bus.ew_yellow = lamps_q.ew.yellow;
    assign bus.ew_green  = lamps_q.ew.green;
    assign bus.cnt_tens  = cnt_tens;
    assign bus.cnt_ones  = cnt_ones;
    assign bus.tick      = tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl with a small integer phase model
// and an expectation queue; honours TRAFFIC_PED_REQ_EN when defined.
module tb_traffic_phase_ctrl;

    localparam int TD = 4;
    localparam int G  = 12;
    localparam int Y  = 3;
    localparam int A  = 1;
    localparam int P  = 5;
`ifdef TRAFFIC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    traffic_phase_ctrl_if bus ();

    traffic_phase_ctrl #(
        .TICK_DIV    (TD),
        .GREEN_SEC   (G),
        .YELLOW_SEC  (Y),
        .ALLRED_SEC  (A),
        .PED_MIN_SEC (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_phase;
    int          m_rem;
    bit          m_ped;
    logic [13:0] exp_q[$];

    function automatic int dur(input int p);
        case (p)
            0, 3:    return G;
            1, 4:    return Y;
            default: return A;
        endcase
    endfunction

    // {ns_r,ns_y,ns_g, ew_r,ew_y,ew_g, tens, ones}
    function automatic logic [13:0] exp_vec(input int p, input int r);
        logic [5:0] l;
        case (p)
            0:       l = 6'b001_100;
            1:       l = 6'b010_100;
            3:       l = 6'b100_001;
            4:       l = 6'b100_010;
            default: l = 6'b100_100;
        endcase
        return {l, 4'(r / 10), 4'(r % 10)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.ns_red, bus.ns_yellow, bus.ns_green,
                bus.ew_red, bus.ew_yellow, bus.ew_green,
                bus.cnt_tens, bus.cnt_ones};
    endfunction

    function automatic void model_step();
        if (m_rem == 1) begin
            m_phase = (m_phase + 1) % 6;
            m_rem   = dur(m_phase);
            if (m_phase == 2 || m_phase == 5) m_ped = 1'b0;
        end else if (PED_EN && m_ped && (m_phase == 0 || m_phase == 3) && m_rem > P) begin
            m_rem = P;
        end else begin
            m_rem = m_rem - 1;
        end
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst         = 1'b1;
        bus.ped_req = 1'b0;
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        m_phase = 0;
        m_rem   = G;
        m_ped   = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TD + 1; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ped_pulse();
        bus.ped_req = 1'b1;
        if (PED_EN) m_ped = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        rst         = 1'b1;
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(exp_vec(0, G));
        e = exp_q.pop_front();
        n_cmp++;
        if (dut_vec() !== e) begin
            n_bad++;
            $display("FAIL reset_state: got %h required %h", dut_vec(), e);
        end
        n_cmp++;
        if (bus.tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got %b required 0", bus.tick);
        end
        rst     = 1'b0;
        m_phase = 0;
        m_rem   = G;
        m_ped   = 1'b0;
        for (int c = 1; c <= TD; c++) begin
            @(negedge clk);
            if (c < TD) begin
                n_cmp++;
                if (bus.tick !== 1'(c == TD - 1)) begin
                    n_bad++;
                    $display("FAIL first_tick[%0d]: got %b required %b", c, bus.tick, (c == TD - 1));
                end
                n_cmp++;
                if (dut_vec() !== exp_vec(0, G)) begin
                    n_bad++;
                    $display("FAIL hold_after_release[%0d]: got %h required %h", c, dut_vec(), exp_vec(0, G));
                end
                if (c == TD - 1) begin
                    model_step();
                    exp_q.push_back(exp_vec(m_phase, m_rem));
                end
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (dut_vec() !== e) begin
                    n_bad++;
                    $display("FAIL first_decrement: got %h required %h", dut_vec(), e);
                end
            end
        end
    endtask

    task automatic test_full_cycle();
        logic [13:0] e;
        int          back_at;
        int          ns_n;
        int          ew_n;
        back_at = 0;
        do_reset(2);
        for (int c = 1; c <= 40 * TD; c++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (dut_vec() !== e) begin
                    n_bad++;
                    $display("FAIL full_cycle[%0d]: got %h required %h", c, dut_vec(), e);
                end
            end
            ns_n = int'(bus.ns_red) + int'(bus.ns_yellow) + int'(bus.ns_green);
            ew_n = int'(bus.ew_red) + int'(bus.ew_yellow) + int'(bus.ew_green);
            n_cmp++;
            if (!(ns_n == 1 && ew_n == 1 && (bus.ns_red === 1'b1 || bus.ew_red === 1'b1))) begin
                n_bad++;
                $display("FAIL lamp_safety[%0d]: got ns=%0d ew=%0d lamps, required one each with a red", c, ns_n, ew_n);
            end
            n_cmp++;
            if (bus.tick !== 1'((c % TD) == TD - 1)) begin
                n_bad++;
                $display("FAIL tick_period[%0d]: got %b required %b", c, bus.tick, ((c % TD) == TD - 1));
            end
            if (back_at != 0 && c == back_at) break;
            if (bus.tick === 1'b1) begin
                model_step();
                exp_q.push_back(exp_vec(m_phase, m_rem));
                if (m_phase == 0 && m_rem == G) back_at = c + 1;
            end
        end
        n_cmp++;
        if (back_at != 128) begin
            n_bad++;
            $display("FAIL cycle_length: got %0d required 128", back_at);
        end
    endtask

    task automatic test_borrow();
        logic [13:0] e;
        bit          ok;
        do_reset(1);
        for (int t = 0; t < 13; t++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL borrow_tick[%0d]: got no tick, required one within %0d cycles", t, TD + 1);
                break;
            end
            model_step();
            exp_q.push_back(exp_vec(m_phase, m_rem));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== e) begin
                n_bad++;
                $display("FAIL borrow[%0d]: got %h required %h", t, dut_vec(), e);
            end
        end
    endtask

    task automatic test_ped_cut();
        logic [13:0] e;
        bit          ok;
        do_reset(1);
        for (int t = 0; t < 24; t++) begin
            if (t == 2) ped_pulse();
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL ped_tick[%0d]: got no tick, required one within %0d cycles", t, TD + 1);
                break;
            end
            model_step();
            exp_q.push_back(exp_vec(m_phase, m_rem));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== e) begin
                n_bad++;
                $display("FAIL ped_cut[%0d]: got %h required %h", t, dut_vec(), e);
            end
        end
    endtask

    task automatic test_late_ped();
        logic [13:0] e;
        bit          ok;
        do_reset(1);
        for (int t = 0; t < 13; t++) begin
            if (t == 7 || t == 9) ped_pulse();
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL late_ped_tick[%0d]: got no tick, required one within %0d cycles", t, TD + 1);
                break;
            end
            model_step();
            exp_q.push_back(exp_vec(m_phase, m_rem));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== e) begin
                n_bad++;
                $display("FAIL late_ped[%0d]: got %h required %h", t, dut_vec(), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] e;
        bit          ok;
        do_reset(1);
        for (int t = 0; t < 29; t++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL mid_tick[%0d]: got no tick, required one within %0d cycles", t, TD + 1);
                break;
            end
            model_step();
            exp_q.push_back(exp_vec(m_phase, m_rem));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== e) begin
                n_bad++;
                $display("FAIL mid_run[%0d]: got %h required %h", t, dut_vec(), e);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_phase = 0;
        m_rem   = G;
        m_ped   = 1'b0;
        exp_q.push_back(exp_vec(m_phase, m_rem));
        e = exp_q.pop_front();
        n_cmp++;
        if (dut_vec() !== e) begin
            n_bad++;
            $display("FAIL mid_reset_state: got %h required %h", dut_vec(), e);
        end
        n_cmp++;
        if (bus.tick !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_tick: got %b required 0", bus.tick);
        end
        for (int c = 1; c < TD; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.tick !== 1'(c == TD - 1)) begin
                n_bad++;
                $display("FAIL mid_reset_prescale[%0d]: got %b required %b", c, bus.tick, (c == TD - 1));
            end
        end
    endtask

    initial begin
        bus.ped_req = 1'b0;
        test_reset();
        test_full_cycle();
        test_borrow();
        test_ped_cut();
        test_late_ped();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000, required finish");
        $fatal(1);
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Two-direction intersection sequencer that drives the north-south and east-west light sets and supplies a two-digit BCD countdown of the seconds remaining in the current phase. It is the controller for the BCD countdown display path: a top level feeds `cnt_tens`/`cnt_ones` into the existing BCD-to-7-segment decoders, and the lamp outputs go straight to the LED pins. A prescaler derives a one-second tick from `clk`. An optional pedestrian request shortens the active green phase.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles per one-second tick; must be ≥ 2.
- `GREEN_SEC`, 25: green phase length in ticks; range 1..99.
- `YELLOW_SEC`, 3: yellow phase length in ticks; range 1..99.
- `ALLRED_SEC`, 1: all-red clearance length in ticks; range 1..99.
- `PED_MIN_SEC`, 5: remaining green after a pedestrian cut; must satisfy 1 ≤ `PED_MIN_SEC` < `GREEN_SEC`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `ped_req`  in  1  pedestrian button, level, already synchronised.
- `ns_red`, `ns_yellow`, `ns_green`  out  1 each  north-south lamps.
- `ew_red`, `ew_yellow`, `ew_green`  out  1 each  east-west lamps.
- `cnt_tens`  out  4  BCD tens digit of seconds remaining.
- `cnt_ones`  out  4  BCD ones digit of seconds remaining.
- `tick`  out  1  one-cycle pulse on each second boundary.

## Operation
- FSM states and fixed cycle order:
  - `NS_GO` → `NS_WARN` → `CLR_A` → `EW_GO` → `EW_WARN` → `CLR_B` → `NS_GO`.
- Lamps per state (all outputs registered):
  - `NS_GO`: `ns_green`, `ew_red`.
  - `NS_WARN`: `ns_yellow`, `ew_red`.
  - `CLR_A` and `CLR_B`: `ns_red`, `ew_red`.
  - `EW_GO`: `ns_red`, `ew_green`.
  - `EW_WARN`: `ns_red`, `ew_yellow`.
  - Exactly one lamp per direction is ever lit.
  - At no time are both directions showing anything other than red.
- Durations are loaded on phase entry:
  - `*_GO` loads `GREEN_SEC`.
  - `*_WARN` loads `YELLOW_SEC`.
  - `CLR_*` loads `ALLRED_SEC`.
  - Constants are converted to BCD at elaboration.
- Countdown, applied on each `tick`:
  - If the count is 01: advance the state and load the next duration.
  - Otherwise: decrement the count in BCD. When ones = 0, ones becomes 9 and tens decrements.
  - The display therefore shows D down to 1, and each phase lasts exactly D ticks.
- The count never reads 00 and never holds a non-BCD nibble.

## Timing
- Prescaler:
  - `div_cnt` counts 0..`TICK_DIV`−1 and wraps.
  - `tick` = 1 on the cycle where `div_cnt` == `TICK_DIV`−1.
  - State, count and lamps update on the clock edge that ends the `tick` cycle, so outputs change one cycle after `tick` is seen high.
- Reset values (held while `rst` = 1, first tick `TICK_DIV` cycles after release):
  - State `NS_GO`; `ns_green` = 1, `ew_red` = 1, all other lamps 0.
  - Count = `GREEN_SEC` in BCD.
  - `div_cnt` = 0, `tick` = 0, pedestrian latch = 0.
- Reset asserted mid-phase: takes effect on the next edge regardless of `tick`, and the phase restarts from `NS_GO`.

## Configuration
- Macro: `TRAFFIC_PED_REQ_EN`.
- Defined:
  - `ped_latch` sets on any cycle with `ped_req` = 1.
  - `ped_latch` clears on entry to `CLR_A` or `CLR_B`. If set and clear coincide, set wins, so the request is served in the next green.
  - On a `tick` in `NS_GO` or `EW_GO` with `ped_latch` = 1 and count > `PED_MIN_SEC`, the count loads `PED_MIN_SEC` instead of decrementing.
  - If count ≤ `PED_MIN_SEC`, the normal decrement applies.
- Undefined:
  - `ped_req` is ignored and the latch is not built.
  - Green always lasts `GREEN_SEC` ticks.

## Structure
- Shared package `traffic_pkg`:
  - State enum `phase_t`.
  - BCD nibble typedef.
  - Function `to_bcd2(int)` returning {tens, ones}.
- Sub-module `bcd2_down_counter`:
  - Two-digit BCD counter with load and decrement-enable inputs.
  - Outputs the digits and an `is_one` flag.
- Prescaler, FSM and pedestrian latch live in `traffic_phase_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4, `GREEN_SEC`=12, `YELLOW_SEC`=3, `ALLRED_SEC`=1, `PED_MIN_SEC`=5.
- Reset release:
  - Lamps `ns_green`, `ew_red`; count 1,2.
  - First `tick` at cycle 3 after release.
  - Count 1,1 one cycle later.
- Full cycle:
  - Sequence lasts 12/3/1/12/3/1 ticks = 128 cycles, then returns to `NS_GO` with count 1,2.
  - Never more than one lamp per direction; never a non-red pair.
- BCD borrow: count 1,0 → 0,9 on a `tick`; 0,1 → next phase loaded on a `tick`.
- Pedestrian cut (macro defined):
  - `ped_req` pulse at count 1,0 in `NS_GO` → next tick count 0,5.
  - Latch clears entering `CLR_A`.
  - `EW_GO` runs the full 12 ticks.
- Late pedestrian and no-macro build:
  - Request at count 0,3 → normal decrement to 0,2.
  - Macro undefined → `ped_req` has no effect.
- Mid-phase reset: `rst` pulse during `EW_WARN` → next cycle `NS_GO`, count 1,2, `div_cnt` 0.
